// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snn_pkg
// Description : Shared constants and state encoding for the post-synaptic
//               step scheduler and the blocks around it (neuron core,
//               post-synaptic buffer).
// Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

  // Layer geometry, shared with the post-synaptic buffer
  localparam int N_NEURON   = 18;
  localparam int IDX_W      = 5;

  // Scheduler sizing
  localparam int STEP_W     = 8;
  localparam int PB_TIMEOUT = 4;
  localparam int WAIT_W     = (PB_TIMEOUT > 1) ? $clog2(PB_TIMEOUT) : 1;

  // Highest neuron index visited by a sweep
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURON - 1);

  // Scheduler state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INIT    = 3'd1;
  localparam logic [2:0] ST_REQ     = 3'd2;
  localparam logic [2:0] ST_PB_WAIT = 3'd3;
  localparam logic [2:0] ST_LEARN   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_INIT    = ST_INIT,
    S_REQ     = ST_REQ,
    S_PB_WAIT = ST_PB_WAIT,
    S_LEARN   = ST_LEARN,
    S_DONE    = ST_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/post_step_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : post_step_sched_if
// Description : Bundle of the sample-control, neuron-core, post-synaptic
//               buffer and learning-engine signals around the scheduler.
//               master = scheduler side, slave = surrounding blocks.
// Revision    : 1.0 - initial release
// ============================================================================
interface post_step_sched_if;
  import snn_pkg::*;

  // Sample controller
  logic              i_start;
  logic [STEP_W-1:0] i_num_steps;
  logic [STEP_W-1:0] o_step_cnt;
  logic              o_busy;
  logic              o_sample_done;
  logic              o_err;

  // Neuron core
  logic              o_nrn_req;
  logic [IDX_W-1:0]  o_nrn_idx;
  logic              i_nrn_ack;
  logic              i_nrn_spike;

  // Post-synaptic buffer
  logic              o_pb_valid;
  logic              o_pb_spike;
  logic [IDX_W-1:0]  o_pb_neuron_idx;
  logic              o_pb_s_init;
  logic              o_pb_cnt_clr;
  logic              i_pb_valid;

  // Learning engine
  logic              o_learn_start;
  logic              i_learn_done;

  modport master (
    input  i_start, i_num_steps, i_nrn_ack, i_nrn_spike, i_pb_valid, i_learn_done,
    output o_step_cnt, o_busy, o_sample_done, o_err,
           o_nrn_req, o_nrn_idx,
           o_pb_valid, o_pb_spike, o_pb_neuron_idx, o_pb_s_init, o_pb_cnt_clr,
           o_learn_start
  );

  modport slave (
    output i_start, i_num_steps, i_nrn_ack, i_nrn_spike, i_pb_valid, i_learn_done,
    input  o_step_cnt, o_busy, o_sample_done, o_err,
           o_nrn_req, o_nrn_idx,
           o_pb_valid, o_pb_spike, o_pb_neuron_idx, o_pb_s_init, o_pb_cnt_clr,
           o_learn_start
  );

endinterface
`default_nettype wire

// File: rtl/post_step_sched.sv
`default_nettype none
// ============================================================================
// Module      : post_step_sched
// Description : Sequences the post-synaptic buffer for one input sample:
//               trace init + counter clear, then per timestep a neuron sweep
//               (each result forwarded to the buffer), a wait for the
//               buffer's end-of-sweep valid and one learning phase.
// Revision    : 1.0 - initial release
// ============================================================================
module post_step_sched
  import snn_pkg::*;
(
  input  wire logic            clk,
  input  wire logic            rst,
  post_step_sched_if.master    bus
);

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [STEP_W-1:0]   r_step_cnt;
  logic [STEP_W-1:0]   r_steps;
  logic [WAIT_W-1:0]   r_wait_cnt;

  logic                r_nrn_req;
  logic [IDX_W-1:0]    r_nrn_idx;
  logic                r_pb_valid;
  logic                r_pb_spike;
  logic [IDX_W-1:0]    r_pb_neuron_idx;
  logic                r_pb_s_init;
  logic                r_pb_cnt_clr;
  logic                r_learn_start;
  logic                r_busy;
  logic                r_sample_done;
  logic                r_err;

  // A programmed step count of zero still runs one timestep
  logic [STEP_W-1:0]   w_steps_in;
  assign w_steps_in = (bus.i_num_steps == '0) ? STEP_W'(1) : bus.i_num_steps;

  // Scheduler FSM; every output is a register updated alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_idx           <= '0;
      r_step_cnt      <= '0;
      r_steps         <= '0;
      r_wait_cnt      <= '0;
      r_nrn_req       <= 1'b0;
      r_nrn_idx       <= '0;
      r_pb_valid      <= 1'b0;
      r_pb_spike      <= 1'b0;
      r_pb_neuron_idx <= '0;
      r_pb_s_init     <= 1'b0;
      r_pb_cnt_clr    <= 1'b0;
      r_learn_start   <= 1'b0;
      r_busy          <= 1'b0;
      r_sample_done   <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      // Single-cycle strobes fall back to zero unless a branch re-arms them
      r_pb_cnt_clr  <= 1'b0;
      r_pb_valid    <= 1'b0;
      r_learn_start <= 1'b0;
      r_sample_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_state         <= S_INIT;
            r_idx           <= '0;
            r_step_cnt      <= '0;
            r_steps         <= w_steps_in;
            r_err           <= 1'b0;
            r_busy          <= 1'b1;
            // First INIT cycle: trace init for neuron 0 plus counter clear
            r_pb_s_init     <= 1'b1;
            r_pb_neuron_idx <= '0;
            r_pb_cnt_clr    <= 1'b1;
          end
        end

        S_INIT: begin
          if (r_idx == LAST_IDX) begin
            r_state         <= S_REQ;
            r_idx           <= '0;
            r_pb_s_init     <= 1'b0;
            r_pb_neuron_idx <= '0;
            r_nrn_req       <= 1'b1;
            r_nrn_idx       <= '0;
          end else begin
            r_idx           <= r_idx + 1'b1;
            r_pb_neuron_idx <= r_idx + 1'b1;
          end
        end

        S_REQ: begin
          if (r_nrn_req) begin
            // Request phase: hold until the core answers
            if (bus.i_nrn_ack) begin
              r_nrn_req       <= 1'b0;
              r_pb_valid      <= 1'b1;
              r_pb_spike      <= bus.i_nrn_spike;
              r_pb_neuron_idx <= r_idx;
            end
          end else begin
            // Write phase: buffer write is on the bus, any ack is ignored
            r_pb_spike <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_state    <= S_PB_WAIT;
              r_wait_cnt <= '0;
            end else begin
              r_idx     <= r_idx + 1'b1;
              r_nrn_req <= 1'b1;
              r_nrn_idx <= r_idx + 1'b1;
            end
          end
        end

        S_PB_WAIT: begin
          // A missing end-of-sweep valid is flagged but never stalls learning
          if (bus.i_pb_valid || (r_wait_cnt == WAIT_W'(PB_TIMEOUT - 1))) begin
            if (!bus.i_pb_valid) begin
              r_err <= 1'b1;
            end
            r_state       <= S_LEARN;
            r_learn_start <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        S_LEARN: begin
          if (bus.i_learn_done) begin
            if (r_step_cnt == r_steps - 1'b1) begin
              r_state       <= S_DONE;
              r_sample_done <= 1'b1;
            end else begin
              // Next timestep sweeps again without re-initialising traces
              r_step_cnt <= r_step_cnt + 1'b1;
              r_state    <= S_REQ;
              r_idx      <= '0;
              r_nrn_req  <= 1'b1;
              r_nrn_idx  <= '0;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping
  assign bus.o_nrn_req       = r_nrn_req;
  assign bus.o_nrn_idx       = r_nrn_idx;
  assign bus.o_pb_valid      = r_pb_valid;
  assign bus.o_pb_spike      = r_pb_spike;
  assign bus.o_pb_neuron_idx = r_pb_neuron_idx;
  assign bus.o_pb_s_init     = r_pb_s_init;
  assign bus.o_pb_cnt_clr    = r_pb_cnt_clr;
  assign bus.o_learn_start   = r_learn_start;
  assign bus.o_step_cnt      = r_step_cnt;
  assign bus.o_busy          = r_busy;
  assign bus.o_sample_done   = r_sample_done;
  assign bus.o_err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_post_step_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_post_step_sched
// Description : Self-checking bench for post_step_sched. Randomised neuron-core
//               and learning-engine responders, a passive monitor, and an
//               expectation list built from the sample rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_post_step_sched;
  import snn_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  post_step_sched_if bus();

  post_step_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // ---------------- responder configuration ----------------
  bit tie_ack  = 1'b0;
  int max_dly  = 0;
  bit pb_auto  = 1'b1;
  int ack_n    = 0;
  bit spk_tab [0:255];

  int  r_dly   = 0;
  bit  r_pend  = 1'b0;
  int  l_dly   = 0;
  bit  l_pend  = 1'b0;

  // Neuron core, buffer-valid and learning engine responders
  initial begin
    bus.i_nrn_ack    = 1'b0;
    bus.i_nrn_spike  = 1'b0;
    bus.i_pb_valid   = 1'b0;
    bus.i_learn_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.o_nrn_req) begin
        if (!r_pend) begin
          r_pend = 1'b1;
          r_dly  = tie_ack ? 0 : int'($urandom_range(0, max_dly));
        end
        if (r_dly == 0) begin
          bus.i_nrn_ack   = 1'b1;
          bus.i_nrn_spike = spk_tab[ack_n % 256];
          ack_n++;
          r_pend = 1'b0;
        end else begin
          bus.i_nrn_ack   = 1'b0;
          bus.i_nrn_spike = 1'($urandom);
          r_dly--;
        end
      end else begin
        bus.i_nrn_ack   = tie_ack;
        bus.i_nrn_spike = 1'($urandom);
        r_pend = 1'b0;
      end
      bus.i_pb_valid = pb_auto;
      if (bus.o_learn_start) begin
        l_pend = 1'b1;
        l_dly  = int'($urandom_range(0, 2));
      end
      if (l_pend && l_dly == 0) begin
        bus.i_learn_done = 1'b1;
        l_pend = 1'b0;
      end else begin
        bus.i_learn_done = 1'b0;
        if (l_pend) l_dly--;
      end
    end
  end

  // ---------------- monitor ----------------
  int q_init[$];
  int q_init_err[$];
  int q_clr[$];
  int q_wr_idx[$];
  int q_wr_spk[$];
  int q_wr_step[$];
  int q_ls_step[$];
  int q_ls_err[$];
  int q_ls_gap[$];
  int cyc = 0;
  int last_wr_cyc = 0;
  int done_n = 0;
  int viol = 0;
  bit prev_valid = 1'b0;

  // Records every strobe the scheduler emits, sampled mid-cycle
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_pb_s_init) begin
      q_init.push_back(int'(bus.o_pb_neuron_idx));
      q_init_err.push_back(int'(bus.o_err));
    end
    if (bus.o_pb_cnt_clr)
      q_clr.push_back(bus.o_pb_s_init ? int'(bus.o_pb_neuron_idx) : 99);
    if (bus.o_pb_valid) begin
      q_wr_idx.push_back(int'(bus.o_pb_neuron_idx));
      q_wr_spk.push_back(int'(bus.o_pb_spike));
      q_wr_step.push_back(int'(bus.o_step_cnt));
      if (prev_valid || bus.o_nrn_req || bus.o_pb_s_init) viol <= viol + 1;
      last_wr_cyc <= cyc;
    end
    prev_valid <= bus.o_pb_valid;
    if (bus.o_learn_start) begin
      q_ls_step.push_back(int'(bus.o_step_cnt));
      q_ls_err.push_back(int'(bus.o_err));
      q_ls_gap.push_back(cyc - last_wr_cyc);
    end
    if (bus.o_sample_done) done_n <= done_n + 1;
  end

  // ---------------- one complete sample with reference checks ----------------
  task automatic run_sample(input string nm, input int nsteps, input int mdly,
                            input bit tie, input bit pbauto, input bit inject,
                            input bit pat3);
    int se, b_init, b_clr, b_wr, b_ls, b_done, b_viol, bad, n, exp_gap;
    bit fin, injected;
    se      = (nsteps == 0) ? 1 : nsteps;
    b_init  = q_init.size();
    b_clr   = q_clr.size();
    b_wr    = q_wr_idx.size();
    b_ls    = q_ls_step.size();
    b_done  = done_n;
    b_viol  = viol;
    fin     = 1'b0;
    injected = 1'b0;
    exp_gap = pbauto ? 2 : PB_TIMEOUT + 1;
    for (int k = 0; k < se * N_NEURON; k++)
      spk_tab[k] = pat3 ? ((k % N_NEURON) == 3) : 1'($urandom);
    ack_n   = 0;
    tie_ack = tie;
    max_dly = mdly;
    pb_auto = pbauto;

    bus.i_num_steps = STEP_W'(nsteps);
    bus.i_start     = 1'b1;
    @(negedge clk); #1;
    bus.i_start     = 1'b0;
    bus.i_num_steps = STEP_W'($urandom);
    for (int c = 0; c < 4000 && !fin; c++) begin
      @(negedge clk); #1;
      bus.i_start = 1'b0;
      if (inject && !injected && bus.o_learn_start) begin
        bus.i_start     = 1'b1;
        bus.i_num_steps = STEP_W'(7);
        injected = 1'b1;
      end
      if (done_n != b_done) fin = 1'b1;
    end
    chk({nm, "/done_seen"}, 32'(fin), 1);
    repeat (3) @(negedge clk);
    #1;
    chk({nm, "/done_pulses"}, 32'(done_n - b_done), 1);

    n = q_init.size() - b_init;
    chk({nm, "/init_count"}, 32'(n), N_NEURON);
    bad = 0;
    for (int i = 0; i < n && i < N_NEURON; i++)
      if (q_init[b_init + i] != i) bad++;
    chk({nm, "/init_order"}, 32'(bad), 0);
    if (n > 0) chk({nm, "/err_at_init"}, 32'(q_init_err[b_init]), 0);
    n = q_clr.size() - b_clr;
    chk({nm, "/clr_count"}, 32'(n), 1);
    if (n > 0) chk({nm, "/clr_first"}, 32'(q_clr[b_clr]), 0);

    n = q_wr_idx.size() - b_wr;
    chk({nm, "/wr_count"}, 32'(n), 32'(se * N_NEURON));
    bad = 0;
    for (int k = 0; k < n && k < se * N_NEURON; k++) begin
      if (q_wr_idx[b_wr + k]  != k % N_NEURON)  bad++;
      if (q_wr_spk[b_wr + k]  != int'(spk_tab[k])) bad++;
      if (q_wr_step[b_wr + k] != k / N_NEURON)  bad++;
    end
    chk({nm, "/wr_content"}, 32'(bad), 0);

    n = q_ls_step.size() - b_ls;
    chk({nm, "/learn_count"}, 32'(n), 32'(se));
    bad = 0;
    for (int j = 0; j < n && j < se; j++) begin
      if (q_ls_step[b_ls + j] != j)            bad++;
      if (q_ls_err[b_ls + j]  != int'(!pbauto)) bad++;
      if (q_ls_gap[b_ls + j]  != exp_gap)       bad++;
    end
    chk({nm, "/learn_content"}, 32'(bad), 0);

    chk({nm, "/protocol"}, 32'(viol - b_viol), 0);
    chk({nm, "/busy_idle"}, 32'(bus.o_busy), 0);
    chk({nm, "/step_hold"}, 32'(bus.o_step_cnt), 32'(se - 1));
    chk({nm, "/err_final"}, 32'(bus.o_err), 32'(!pbauto));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int b_wr;
    bit found;
    bus.i_start     = 1'b0;
    bus.i_num_steps = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst/strobes", 32'({bus.o_nrn_req, bus.o_pb_valid, bus.o_pb_spike, bus.o_pb_s_init,
                            bus.o_pb_cnt_clr, bus.o_learn_start, bus.o_busy,
                            bus.o_sample_done, bus.o_err}), 0);
    chk("rst/step_cnt", 32'(bus.o_step_cnt), 0);
    chk("rst/indices", 32'({bus.o_nrn_idx, bus.o_pb_neuron_idx}), 0);
    rst = 1'b0;
    @(negedge clk); #1;

    run_sample("single",  1, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    run_sample("delayed", 3, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    run_sample("timeout", 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_sample("zero",    0, 2, 1'b0, 1'b1, 1'b0, 1'b0);

    // Abort in the middle of a sweep
    tie_ack = 1'b1;
    pb_auto = 1'b1;
    ack_n   = 0;
    bus.i_num_steps = STEP_W'(2);
    bus.i_start     = 1'b1;
    @(negedge clk); #1;
    bus.i_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk); #1;
      if (bus.o_nrn_req && bus.o_nrn_idx == IDX_W'(9)) found = 1'b1;
    end
    chk("abort/reached_idx9", 32'(found), 1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("abort/strobes", 32'({bus.o_nrn_req, bus.o_pb_valid, bus.o_pb_spike, bus.o_pb_s_init,
                              bus.o_pb_cnt_clr, bus.o_learn_start, bus.o_busy,
                              bus.o_sample_done, bus.o_err}), 0);
    chk("abort/step_cnt", 32'(bus.o_step_cnt), 0);
    chk("abort/indices", 32'({bus.o_nrn_idx, bus.o_pb_neuron_idx}), 0);
    rst = 1'b0;
    b_wr = q_wr_idx.size();
    repeat (5) @(negedge clk);
    #1;
    chk("abort/quiet_writes", 32'(q_wr_idx.size() - b_wr), 0);
    chk("abort/quiet_busy", 32'(bus.o_busy), 0);

    run_sample("restart", 1, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_sample("inject",  2, 2, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/post_step_sched.md
Name: post_step_sched

Overview:
- Sequences the post-synaptic buffer for one input sample.
- Initialises the per-neuron traces and clears the spike counters.
- Sweeps the neuron core once per timestep, neuron by neuron, and forwards each returned spike into the post-synaptic buffer.
- Waits for the buffer's end-of-sweep valid, runs one learning phase per timestep, then repeats for the programmed number of timesteps. Sits between the top-level sample controller, the neuron core, the post-synaptic buffer and the learning engine.

Parameters:
N_NEURON, 18, neurons per layer; sweep covers indices 0..N_NEURON-1
IDX_W, 5, neuron index width
STEP_W, 8, timestep counter width
PB_TIMEOUT, 4, max cycles to wait for buffer end-of-sweep valid

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_start  in  1  start-sample pulse; honoured only in IDLE
i_num_steps  in  STEP_W  timesteps per sample; latched on accepted i_start; 0 treated as 1
o_nrn_req  out  1  request neuron update for o_nrn_idx
o_nrn_idx  out  IDX_W  neuron being requested
i_nrn_ack  in  1  neuron core result valid; may arrive the same cycle as req or later
i_nrn_spike  in  1  spike result, qualified by i_nrn_ack
o_pb_valid  out  1  buffer write strobe
o_pb_spike  out  1  spike to buffer
o_pb_neuron_idx  out  IDX_W  buffer neuron index
o_pb_s_init  out  1  buffer trace-init strobe
o_pb_cnt_clr  out  1  buffer spike-counter clear
i_pb_valid  in  1  buffer end-of-sweep valid
o_learn_start  out  1  one-cycle pulse to start the learning engine
i_learn_done  in  1  learning engine completion pulse
o_step_cnt  out  STEP_W  current timestep index
o_busy  out  1  high in every state except IDLE
o_sample_done  out  1  one-cycle pulse when the sample completes
o_err  out  1  sticky error: PB_WAIT timeout; cleared by rst or an accepted i_start

Behaviour:
- Reset: state IDLE. All outputs are 0, o_step_cnt is 0 and o_err is 0. Reset in mid-operation aborts immediately, with no further strobes emitted.
- All outputs are registered.
- States: IDLE, INIT, REQ, PB_WAIT, LEARN, DONE.
- IDLE:
  - i_start → INIT.
  - On transition: idx=0, step_cnt=0, o_err=0; latch steps=max(i_num_steps,1).
- INIT:
  - Lasts N_NEURON cycles. In cycle k: o_pb_s_init=1, o_pb_neuron_idx=k.
  - o_pb_cnt_clr=1 on the first INIT cycle only.
  - o_pb_valid stays 0.
  - After k=N_NEURON-1 → REQ with idx=0.
- REQ:
  - o_nrn_req=1 and o_nrn_idx=idx, held until i_nrn_ack.
  - On an ack cycle, the next cycle carries o_pb_valid=1, o_pb_spike=i_nrn_spike, o_pb_neuron_idx=idx.
  - o_nrn_req drops for exactly that cycle, then re-asserts for idx+1.
  - The buffer therefore receives strictly ordered indices 0..N_NEURON-1, one write per neuron, never back-to-back.
  - After the write for idx=N_NEURON-1 → PB_WAIT.
  - An i_nrn_ack while o_nrn_req=0 is ignored.
- PB_WAIT:
  - Waits for i_pb_valid, then → LEARN and pulses o_learn_start in the first LEARN cycle.
  - If i_pb_valid is absent for PB_TIMEOUT cycles: set o_err, proceed to LEARN anyway.
- LEARN:
  - Waits for i_learn_done. An i_learn_done arriving in the same cycle as o_learn_start is accepted.
  - If step_cnt==steps-1 → DONE.
  - Otherwise step_cnt+1 and → REQ with idx=0. No re-init between steps.
- DONE: o_sample_done=1 for one cycle → IDLE. o_step_cnt holds its last value until the next start.
- i_start outside IDLE is ignored.
- Counters never wrap: idx is bounded by N_NEURON-1 and step_cnt by steps-1.

Decomposition:
- Shared package snn_pkg holds:
  - the N_NEURON and IDX_W constants, also used by the buffer;
  - the state encoding localparams.
- No sub-module; a single FSM with idx and step counters.

Test Plan:
- i_start with i_num_steps=1, ack tied high, i_nrn_spike=1 for idx 3 only:
  - 18 INIT cycles of o_pb_s_init with idx 0..17, cnt_clr on the first;
  - 18 pb writes with spike=1 only at idx 3;
  - after i_pb_valid and i_learn_done, o_sample_done pulses once.
- Ack delayed 0..3 random cycles per neuron, i_num_steps=3:
  - exactly 54 pb writes in order 0..17 ×3;
  - o_step_cnt runs 0,1,2;
  - o_learn_start pulses 3 times.
- i_pb_valid withheld → o_err=1 after 4 cycles, LEARN still entered. A subsequent i_start clears o_err.
- i_num_steps=0 → behaves as 1 step, with a single o_sample_done.
- rst asserted mid-REQ (idx=9) → next cycle IDLE, all outputs 0. A fresh i_start restarts with INIT at idx 0.
- i_start pulsed during LEARN → ignored: step count and sequence unchanged.
